obj_dma_sequencer: RTL and testbench
====================================

# obj_dma_sequencer

Sprite-list DMA engine for the Donkey Kong system, modelled on the 8257 channel-0 usage of the original board. On a rising edge of the `dma_rdy` bitmapped-IO bit it requests the bus from the Z80 with a BUSRQ/BUSACK handshake. It then copies `LENGTH` bytes from work RAM (`SRC_BASE`) to object RAM (`DST_BASE`) with alternating read and write cycles, and returns the bus. It sits as the second master on the system bus mux, with `busack` selecting it.

## Interface
- `SRC_BASE`, default `16'h6900`: first source address.
- `DST_BASE`, default `16'h7000`: first destination address.
- `LENGTH`, default `384`: bytes per transfer, range 1..65536.
- `masterclk` in 1: system clock; all state is updated on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cen` in 1: CPU-clock-rise strobe, one `masterclk` wide. All bus phases advance only on `cen`.
- `trigger` in 1: level input from `dma_rdy`; a 0→1 transition requests a transfer.
- `busack` in 1: active-high bus grant from the CPU (inverted BUSAK_n).
- `mem_wait` in 1: active-high slave stall; the current bus cycle is held while it is 1.
- `din` in 8: read data from the slave mux.
- `busrq` out 1: active-high bus request.
- `addr` out 16: bus address.
- `dout` out 8: write data.
- `mreq_n`, `rd_n`, `wr_n` out 1 each: active-low strobes. `iorq_n` is not driven by this block; the top level ties it to 1.
- `active` out 1: high from bus grant until release.
- `done` out 1: one-`masterclk` pulse on normal completion.
- `aborted` out 1: one-`masterclk` pulse when the grant is lost mid-transfer.

## Operation
- **Edge detection**
  - `trigger` is registered every `masterclk`.
  - A rising edge sets `pending`.
  - `pending` is cleared when the FSM leaves IDLE.
  - An edge while busy sets `pending`; several edges while busy collapse into one pending request.
- **States**
  - IDLE: `busrq`=0, strobes=1. Goes to REQ when `pending`=1.
  - REQ: `busrq`=1. On `cen` with `busack`=1: `idx`←0, go to READ.
  - READ: `addr`=`SRC_BASE`+`idx`, `mreq_n`=0, `rd_n`=0. On `cen` with `mem_wait`=0: capture `din`→`data`, go to WRITE.
  - WRITE: `addr`=`DST_BASE`+`idx`, `dout`=`data`, `mreq_n`=0, `wr_n`=0. On `cen` with `mem_wait`=0:
    - if `idx`=`LENGTH`-1, go to RELEASE;
    - otherwise `idx`←`idx`+1 and go to READ.
  - RELEASE: `busrq`=0, strobes=1. Once `busack`=0, pulse `done` and go to IDLE.
- **Arithmetic**
  - `idx` is `$clog2(LENGTH)` bits wide, minimum 1.
  - Address sums are 16-bit modulo 2^16; wrap past FFFFh to 0000h is required behaviour.
- **Abort**: `busack`=0 in READ or WRITE, sampled on any `masterclk`, causes:
  - strobes deassert next clock;
  - `busrq`=0;
  - `aborted` pulses;
  - FSM returns to IDLE; `pending` is not re-set.
- `addr` and `dout` are 0 whenever strobes are inactive.
- `active`=1 in READ and WRITE only.

## Timing
- **Reset values** (asynchronous, immediate): `busrq`=0, `addr`=0, `dout`=0, `mreq_n`=`rd_n`=`wr_n`=1, `active`=0, `done`=0, `aborted`=0, FSM=IDLE, `pending`=0, `idx`=0, `data`=0.
- **Reset mid-transfer**: the bus is released within the same `masterclk` as `rst` rising. A `trigger` level that is already high at reset release is not an edge.
- **Request latency**: `trigger` edge at clock n gives `busrq`=1 at clock n+2 (edge register, then FSM).
- **Transfer length**: each byte takes 2 `cen` periods plus one per `cen` sampled with `mem_wait`=1. With no waits the transfer occupies exactly 2·`LENGTH` `cen` periods between grant and RELEASE.
- Strobes and address change only on the `masterclk` following a qualifying `cen`; they are stable for a full CPU clock period.
- `done` fires one `masterclk` after `busack` is observed low in RELEASE.
- **Simultaneous events**:
  - `mem_wait`=1 and `busack` falling together: abort takes priority.
  - `trigger` edge in the same clock as `done`: `pending` is set, and REQ is re-entered 1 clock after IDLE.

## Test plan
- **Basic copy**: LENGTH=4, SRC=6900h preloaded 11,22,33,44, `cen` every 4 clocks, `busack` 2 `cen` after `busrq` → writes 11,22,33,44 to 7000h–7003h in order, 8 bus cycles, one `done` pulse, `busrq` low.
- **Wait stall**: `mem_wait`=1 for 3 `cen` during the second read → `addr` holds 6901h, `rd_n` stays low, total length is 11 `cen`, data unchanged.
- **Retrigger**: two `trigger` edges during the transfer → exactly one extra transfer follows the first `done`, two `done` pulses in total.
- **Abort**: `busack` dropped during WRITE of byte 2 → strobes high next clock, `aborted`=1 for one clock, no `done`, FSM idle; the next edge restarts from `idx`=0.
- **Async reset mid-READ**: `rst` raised asynchronously between clocks → `mreq_n`=`rd_n`=1 and `busrq`=0 before the next `masterclk` edge.
- **Wrap**: SRC_BASE=FFFEh, LENGTH=4 → read addresses FFFEh, FFFFh, 0000h, 0001h.

Source files
------------

// File: rtl/obj_dma_sequencer.sv
// Sprite-list DMA master: on a trigger edge, takes the bus by BUSRQ/BUSACK and
// copies LENGTH bytes from SRC_BASE to DST_BASE with alternating read/write cycles.
//
// state   | meaning
// IDLE    | bus not requested, waiting for a pending trigger
// REQ     | busrq high, waiting for grant on a cen
// READ    | read cycle at SRC_BASE+idx, din captured on cen without wait
// WRITE   | write cycle at DST_BASE+idx with the captured byte
// RELEASE | busrq dropped, waiting for the CPU to take the bus back
module obj_dma_sequencer #(
  parameter logic [15:0] SRC_BASE = 16'h6900,
  parameter logic [15:0] DST_BASE = 16'h7000,
  parameter int unsigned LENGTH   = 384
) (
  input  logic        masterclk,
  input  logic        rst,
  input  logic        cen,
  input  logic        trigger,
  input  logic        busack,
  input  logic        mem_wait,
  input  logic [7:0]  din,
  output logic        busrq,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        mreq_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        active,
  output logic        done,
  output logic        aborted
);

  localparam int unsigned IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_WRITE,
    S_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             pending_q, pending_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             trig_q, trig_dly_q;
  logic             trig_edge;

  // Trigger history resets high so a level already present at reset release is not an edge.
  assign trig_edge = trig_q & ~trig_dly_q;

  always_ff @(posedge masterclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      trig_q     <= 1'b1;
      trig_dly_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      pending_q  <= pending_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      trig_q     <= trigger;
      trig_dly_q <= trig_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pending_q) state_d = S_REQ;
      end
      S_REQ: begin
        if (cen && busack) begin
          idx_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // Losing the grant beats a wait stall.
        if (!busack) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (cen && !mem_wait) begin
          data_d  = din;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!busack) begin
          aborted_d = 1'b1;
          state_d   = S_IDLE;
        end else if (cen && !mem_wait) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_RELEASE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_READ;
          end
        end
      end
      S_RELEASE: begin
        if (!busack) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_IDLE && state_d != S_IDLE) pending_d = 1'b0;
    if (trig_edge) pending_d = 1'b1;
  end

  // Bus outputs decode straight from state so an async reset frees the bus at once.
  always_comb begin
    busrq  = (state_q == S_REQ) || (state_q == S_READ) || (state_q == S_WRITE);
    active = (state_q == S_READ) || (state_q == S_WRITE);
    mreq_n = !active;
    rd_n   = (state_q != S_READ);
    wr_n   = (state_q != S_WRITE);
    addr   = 16'h0000;
    dout   = 8'h00;
    if (state_q == S_READ) begin
      addr = SRC_BASE + 16'(idx_q);
    end else if (state_q == S_WRITE) begin
      addr = DST_BASE + 16'(idx_q);
      dout = data_q;
    end
  end

  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_obj_dma_sequencer.sv
// Directed bench for obj_dma_sequencer: row tables for the copy and wait-stall
// transfers, hand-written sequences for retrigger, abort, async reset and wrap.
module tb_obj_dma_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic        trigger = 1'b0;
  logic        busack = 1'b0;
  logic        mem_wait = 1'b0;
  logic [7:0]  din;
  logic        busrq, mreq_n, rd_n, wr_n, active, done, aborted;
  logic [15:0] addr;
  logic [7:0]  dout;
  logic        w_busrq, w_mreq_n, w_rd_n, w_wr_n, w_active, w_done, w_aborted;
  logic [15:0] w_addr;
  logic [7:0]  w_dout;

  obj_dma_sequencer #(.SRC_BASE(16'h6900), .DST_BASE(16'h7000), .LENGTH(4)) u_dut (
    .masterclk(clk), .rst(rst), .cen(cen), .trigger(trigger), .busack(busack),
    .mem_wait(mem_wait), .din(din), .busrq(busrq), .addr(addr), .dout(dout),
    .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n), .active(active), .done(done),
    .aborted(aborted)
  );

  obj_dma_sequencer #(.SRC_BASE(16'hFFFE), .DST_BASE(16'h7000), .LENGTH(4)) u_wrap (
    .masterclk(clk), .rst(rst), .cen(cen), .trigger(trigger), .busack(busack),
    .mem_wait(mem_wait), .din(din), .busrq(w_busrq), .addr(w_addr), .dout(w_dout),
    .mreq_n(w_mreq_n), .rd_n(w_rd_n), .wr_n(w_wr_n), .active(w_active), .done(w_done),
    .aborted(w_aborted)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  assign din = mem[addr];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int ncyc = 0;
  logic [23:0] wlog[$];

  always @(posedge clk) begin
    if (cen && !wr_n && !mem_wait) wlog.push_back({addr, dout});
    if (cen && !mreq_n && !mem_wait) ncyc++;
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (aborted) abort_cnt++;
  end

  logic [15:0] wrap_rd [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
  logic [7:0]  dat [4]     = '{8'h11, 8'h22, 8'h33, 8'h44};

  typedef struct {
    logic        ack;
    logic        wt;
    logic [44:0] exp;
  } row_t;

  row_t tbl [22];

  function automatic logic [44:0] pk(logic b, logic m, logic r, logic w, logic a,
                                     logic [15:0] ad, logic [15:0] wa, logic [7:0] d);
    return {b, m, r, w, a, ad, wa, d};
  endfunction

  function automatic logic [44:0] f_idle();
    return pk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 8'h00);
  endfunction

  function automatic logic [44:0] f_req();
    return pk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 8'h00);
  endfunction

  function automatic logic [44:0] f_rd(int i);
    return pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h6900 + 16'(i), wrap_rd[i], 8'h00);
  endfunction

  function automatic logic [44:0] f_wr(int i);
    return pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7000 + 16'(i), 16'h7000 + 16'(i), dat[i]);
  endfunction

  function automatic row_t mk(logic ack, logic wt, logic [44:0] exp);
    row_t r;
    r.ack = ack;
    r.wt  = wt;
    r.exp = exp;
    return r;
  endfunction

  function automatic logic [44:0] cur();
    return pk(busrq, mreq_n, rd_n, wr_n, active, addr, w_addr, dout);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input logic c);
    @(negedge clk);
    cen = c;
    @(posedge clk);
    #1;
  endtask

  task automatic cen_period();
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    tick(1'b1);
    cen = 1'b0;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    trigger = 1'b0;
    tick(1'b0);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      busack   = tbl[i].ack;
      mem_wait = tbl[i].wt;
      cen_period();
      chk($sformatf("row%0d", i), 64'(cur()), 64'(tbl[i].exp));
    end
    mem_wait = 1'b0;
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_nwrites"}, 64'(wlog.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wlog.size())
        chk($sformatf("%s_w%0d", tag, i), 64'(wlog[i]), 64'({16'h7000 + 16'(i), dat[i]}));
    end
  endtask

  task automatic serve(input bit retrig);
    int n;
    n = 0;
    while (busrq !== 1'b1 && n < 50) begin
      tick(1'b0);
      n++;
    end
    chk("serve_req", 64'(busrq), 64'd1);
    busack = 1'b1;
    n = 0;
    while (busrq !== 1'b0 && n < 100) begin
      cen_period();
      n++;
      if (retrig && n == 3) begin
        trigger = 1'b1; tick(1'b0); tick(1'b0);
        trigger = 1'b0; tick(1'b0); tick(1'b0);
        trigger = 1'b1; tick(1'b0); tick(1'b0);
        trigger = 1'b0; tick(1'b0); tick(1'b0);
      end
    end
    chk("serve_rel", 64'(busrq), 64'd0);
    busack = 1'b0;
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int a0;
    int n;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) mem[16'h6900 + i] = dat[i];

    // basic copy: REQ x2, grant, 8 bus cycles, RELEASE
    tbl[0]  = mk(1'b0, 1'b0, f_req());
    tbl[1]  = mk(1'b1, 1'b0, f_rd(0));
    tbl[2]  = mk(1'b1, 1'b0, f_wr(0));
    tbl[3]  = mk(1'b1, 1'b0, f_rd(1));
    tbl[4]  = mk(1'b1, 1'b0, f_wr(1));
    tbl[5]  = mk(1'b1, 1'b0, f_rd(2));
    tbl[6]  = mk(1'b1, 1'b0, f_wr(2));
    tbl[7]  = mk(1'b1, 1'b0, f_rd(3));
    tbl[8]  = mk(1'b1, 1'b0, f_wr(3));
    tbl[9]  = mk(1'b1, 1'b0, f_idle());
    // wait stall on the second read: 3 held cen, 11 cen from grant to RELEASE
    tbl[10] = mk(1'b1, 1'b0, f_rd(0));
    tbl[11] = mk(1'b1, 1'b0, f_wr(0));
    tbl[12] = mk(1'b1, 1'b0, f_rd(1));
    tbl[13] = mk(1'b1, 1'b1, f_rd(1));
    tbl[14] = mk(1'b1, 1'b1, f_rd(1));
    tbl[15] = mk(1'b1, 1'b1, f_rd(1));
    tbl[16] = mk(1'b1, 1'b0, f_wr(1));
    tbl[17] = mk(1'b1, 1'b0, f_rd(2));
    tbl[18] = mk(1'b1, 1'b0, f_wr(2));
    tbl[19] = mk(1'b1, 1'b0, f_rd(3));
    tbl[20] = mk(1'b1, 1'b0, f_wr(3));
    tbl[21] = mk(1'b1, 1'b0, f_idle());

    #1;
    chk("reset_state", 64'({cur(), done, aborted}), 64'({f_idle(), 1'b0, 1'b0}));
    tick(1'b0);
    tick(1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0);
    tick(1'b0);

    // request latency: trigger sampled at clock n, busrq at n+2
    trigger = 1'b1;
    tick(1'b0);
    chk("lat_n", 64'(busrq), 64'd0);
    tick(1'b0);
    chk("lat_n1", 64'(busrq), 64'd0);
    tick(1'b0);
    chk("lat_n2", 64'(busrq), 64'd1);
    trigger = 1'b0;

    wlog.delete();
    ncyc = 0;
    d0 = done_cnt;
    run_rows(0, 9);
    busack = 1'b0;
    tick(1'b0);
    chk("basic_done_hi", 64'(done), 64'd1);
    tick(1'b0);
    chk("basic_done_lo", 64'(done), 64'd0);
    chk("basic_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("basic_bus_cycles", 64'(ncyc), 64'd8);
    check_log("basic");

    // wait stall
    wlog.delete();
    pulse_trigger();
    run_rows(10, 21);
    busack = 1'b0;
    tick(1'b0);
    chk("wait_done_hi", 64'(done), 64'd1);
    tick(1'b0);
    check_log("wait");

    // retrigger: two edges during a transfer give exactly one more transfer
    d0 = done_cnt;
    pulse_trigger();
    serve(1'b1);
    serve(1'b0);
    for (int i = 0; i < 10; i++) cen_period();
    chk("retrig_idle", 64'(busrq), 64'd0);
    chk("retrig_done_cnt", 64'(done_cnt - d0), 64'd2);

    // abort in WRITE of idx 2, with mem_wait rising in the same clock
    d0 = done_cnt;
    a0 = abort_cnt;
    pulse_trigger();
    busack = 1'b1;
    n = 0;
    while (!(addr == 16'h7002 && wr_n == 1'b0) && n < 30) begin
      cen_period();
      n++;
    end
    chk("abort_reach_wr2", 64'({addr, wr_n}), 64'({16'h7002, 1'b0}));
    busack   = 1'b0;
    mem_wait = 1'b1;
    tick(1'b1);
    chk("abort_now", 64'({busrq, mreq_n, rd_n, wr_n, aborted, addr, dout}),
        64'({1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00}));
    mem_wait = 1'b0;
    tick(1'b0);
    chk("abort_pulse_end", 64'(aborted), 64'd0);
    for (int i = 0; i < 8; i++) cen_period();
    chk("abort_no_repend", 64'(busrq), 64'd0);
    chk("abort_cnt", 64'(abort_cnt - a0), 64'd1);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    pulse_trigger();
    busack = 1'b1;
    cen_period();
    chk("abort_restart_idx0", 64'({addr, rd_n, w_addr}), 64'({16'h6900, 1'b0, 16'hFFFE}));
    n = 0;
    while (busrq !== 1'b0 && n < 30) begin
      cen_period();
      n++;
    end
    busack = 1'b0;
    tick(1'b0);
    tick(1'b0);
    chk("abort_restart_done", 64'(done_cnt - d0), 64'd1);

    // async reset in the middle of a READ
    pulse_trigger();
    busack = 1'b1;
    cen_period();
    chk("rst_in_read", 64'({rd_n, addr}), 64'({1'b0, 16'h6900}));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_release", 64'({busrq, mreq_n, rd_n, wr_n, addr}),
        64'({1'b0, 1'b1, 1'b1, 1'b1, 16'h0000}));
    trigger = 1'b1;
    busack  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b0);
    chk("rst_level_not_edge", 64'(busrq), 64'd0);
    trigger = 1'b0;
    tick(1'b0);
    tick(1'b0);
    d0 = done_cnt;
    pulse_trigger();
    serve(1'b0);
    chk("rst_recover_done", 64'(done_cnt - d0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
